pipeline_hazard_ctrl: RTL and testbench



---
 rtl/pipeline_ctrl_pkg.sv | 15 +
 rtl/sat_counter.sv | 21 ++
 rtl/pipeline_hazard_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the uDLX pipeline hazard controller: state encoding,
// default register-address width and the hardwired zero register.
package pipeline_ctrl_pkg;

  localparam int unsigned REG_ADDR_WIDTH_DEF = 5;
  localparam int unsigned ZERO_REG           = 0;
  localparam int unsigned STATE_WIDTH        = 2;

  typedef enum logic [STATE_WIDTH-1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } ctrl_state_e;

endpackage : pipeline_ctrl_pkg

// File: rtl/sat_counter.sv
// Saturating event counter: counts inc pulses and sticks at all-ones.
module sat_counter #(
  parameter int unsigned CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 inc,
  output logic [CNT_WIDTH-1:0] count
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != CNT_MAX)) begin
      count <= count + CNT_WIDTH'(1);
    end
  end

endmodule : sat_counter

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush scheduler for the 5-stage uDLX pipeline: load-use bubbles,
// multi-cycle front-end flush on redirect and full freeze on memory wait.
module pipeline_hazard_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH = REG_ADDR_WIDTH_DEF,
  parameter int unsigned FLUSH_CYCLES   = 1,
  parameter int unsigned CNT_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      id_ex_mem_rd_en,
  input  logic                      id_ex_reg_a_wr_en,
  input  logic [REG_ADDR_WIDTH-1:0] id_ex_reg_a_wr_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2,
  input  logic                      id_rd_use1,
  input  logic                      id_rd_use2,
  input  logic                      ex_redirect,
  input  logic                      mem_req,
  input  logic                      mem_ack,
  output logic                      pc_en,
  output logic                      if_id_en,
  output logic                      if_id_flush,
  output logic                      id_ex_en,
  output logic                      id_ex_flush,
  output logic                      ex_mem_en,
  output logic                      mem_wb_en,
  output logic [CNT_WIDTH-1:0]      stall_count,
  output logic [CNT_WIDTH-1:0]      flush_count
);

  localparam int unsigned FCNT_WIDTH  = 3;
  localparam logic [FCNT_WIDTH-1:0] FLUSH_RELOAD = FCNT_WIDTH'(FLUSH_CYCLES - 1);
  localparam logic [FCNT_WIDTH-1:0] FCNT_LAST    = FCNT_WIDTH'(1);

  ctrl_state_e           state, state_n;
  logic [FCNT_WIDTH-1:0] flush_cnt, flush_cnt_n;
  logic                  load_use, mem_wait;
  logic                  stall_inc, flush_inc;

  assign mem_wait = mem_req & ~mem_ack;

  assign load_use = id_ex_mem_rd_en & id_ex_reg_a_wr_en &
                    (id_ex_reg_a_wr_addr != REG_ADDR_WIDTH'(ZERO_REG)) &
                    ((id_rd_use1 & (id_ex_reg_a_wr_addr == id_rd_addr1)) |
                     (id_rd_use2 & (id_ex_reg_a_wr_addr == id_rd_addr2)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= RUN;
      flush_cnt <= '0;
    end else begin
      state     <= state_n;
      flush_cnt <= flush_cnt_n;
    end
  end

  // Mealy control: a freeze or bubble takes effect in the cycle it is seen.
  always_comb begin
    state_n     = state;
    flush_cnt_n = flush_cnt;
    pc_en       = 1'b0;
    if_id_en    = 1'b0;
    if_id_flush = 1'b0;
    id_ex_en    = 1'b0;
    id_ex_flush = 1'b0;
    ex_mem_en   = 1'b0;
    mem_wb_en   = 1'b0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    if (!rst_n) begin
      state_n     = RUN;
      flush_cnt_n = '0;
    end else if (mem_wait) begin
      // Full freeze; a pending flush holds its position.
      stall_inc = 1'b1;
      if (state != FLUSH) state_n = MEM_WAIT;
    end else begin
      pc_en     = 1'b1;
      if_id_en  = 1'b1;
      id_ex_en  = 1'b1;
      ex_mem_en = 1'b1;
      mem_wb_en = 1'b1;
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        flush_inc   = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_n     = FLUSH;
          flush_cnt_n = FLUSH_RELOAD;
        end else begin
          state_n     = RUN;
          flush_cnt_n = '0;
        end
      end else if (state == FLUSH) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
        if (flush_cnt <= FCNT_LAST) begin
          state_n     = RUN;
          flush_cnt_n = '0;
        end else begin
          flush_cnt_n = flush_cnt - FCNT_WIDTH'(1);
        end
      end else begin
        state_n = RUN;
        if (load_use) begin
          pc_en       = 1'b0;
          if_id_en    = 1'b0;
          id_ex_flush = 1'b1;
          stall_inc   = 1'b1;
        end
      end
    end
  end

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (stall_inc),
    .count (stall_count)
  );

  sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule : pipeline_hazard_ctrl

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: two instances (3-cycle flush / 32-bit counters
// and 1-cycle flush / 4-bit counters) against a flush-countdown reference model.
module tb_pipeline_hazard_ctrl;

  localparam int unsigned AW  = 5;
  localparam int unsigned CW0 = 32;
  localparam int unsigned CW1 = 4;

  typedef struct packed {
    logic          rst;
    logic          mrd;
    logic          wren;
    logic [AW-1:0] waddr;
    logic [AW-1:0] a1;
    logic [AW-1:0] a2;
    logic          u1;
    logic          u2;
    logic          redir;
    logic          req;
    logic          ack;
  } stim_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_ex_mem_rd_en = 1'b0, id_ex_reg_a_wr_en = 1'b0;
  logic [AW-1:0] id_ex_reg_a_wr_addr = '0, id_rd_addr1 = '0, id_rd_addr2 = '0;
  logic          id_rd_use1 = 1'b0, id_rd_use2 = 1'b0;
  logic          ex_redirect = 1'b0, mem_req = 1'b0, mem_ack = 1'b0;

  logic [1:0] pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
  logic [CW0-1:0] sc0, fcc0;
  logic [CW1-1:0] sc1, fcc1;

  int total = 0;
  int bad   = 0;

  // Reference state: remaining flush cycles and unbounded event counts.
  int    fl_rem [2];
  longint scm   [2];
  longint fcm   [2];
  int    fcyc   [2] = '{3, 1};

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .FLUSH_CYCLES(3), .CNT_WIDTH(CW0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_rd_en(id_ex_mem_rd_en), .id_ex_reg_a_wr_en(id_ex_reg_a_wr_en),
    .id_ex_reg_a_wr_addr(id_ex_reg_a_wr_addr), .id_rd_addr1(id_rd_addr1),
    .id_rd_addr2(id_rd_addr2), .id_rd_use1(id_rd_use1), .id_rd_use2(id_rd_use2),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en[0]), .if_id_en(if_id_en[0]), .if_id_flush(if_id_flush[0]),
    .id_ex_en(id_ex_en[0]), .id_ex_flush(id_ex_flush[0]),
    .ex_mem_en(ex_mem_en[0]), .mem_wb_en(mem_wb_en[0]),
    .stall_count(sc0), .flush_count(fcc0)
  );

  pipeline_hazard_ctrl #(.REG_ADDR_WIDTH(AW), .FLUSH_CYCLES(1), .CNT_WIDTH(CW1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .id_ex_mem_rd_en(id_ex_mem_rd_en), .id_ex_reg_a_wr_en(id_ex_reg_a_wr_en),
    .id_ex_reg_a_wr_addr(id_ex_reg_a_wr_addr), .id_rd_addr1(id_rd_addr1),
    .id_rd_addr2(id_rd_addr2), .id_rd_use1(id_rd_use1), .id_rd_use2(id_rd_use2),
    .ex_redirect(ex_redirect), .mem_req(mem_req), .mem_ack(mem_ack),
    .pc_en(pc_en[1]), .if_id_en(if_id_en[1]), .if_id_flush(if_id_flush[1]),
    .id_ex_en(id_ex_en[1]), .id_ex_flush(id_ex_flush[1]),
    .ex_mem_en(ex_mem_en[1]), .mem_wb_en(mem_wb_en[1]),
    .stall_count(sc1), .flush_count(fcc1)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint sat(input int k, input longint v);
    if (k == 1 && v > 15) return 15;
    return v;
  endfunction

  function automatic stim_t idle();
    stim_t s;
    s = '0;
    s.rst = 1'b1;
    return s;
  endfunction

  // Compare both instances against the model, then advance the model one cycle.
  task automatic model_cycle();
    for (int k = 0; k < 2; k++) begin
      logic [6:0] e, act;
      bit lu, frz;
      longint asc, afc;
      e   = '0;
      lu  = id_ex_mem_rd_en && id_ex_reg_a_wr_en && (id_ex_reg_a_wr_addr != 0) &&
            ((id_rd_use1 && id_ex_reg_a_wr_addr == id_rd_addr1) ||
             (id_rd_use2 && id_ex_reg_a_wr_addr == id_rd_addr2));
      frz = mem_req && !mem_ack;
      if (!rst_n) begin
        fl_rem[k] = 0; scm[k] = 0; fcm[k] = 0;
      end else if (frz) begin
        e = 7'b0000000;
      end else if (ex_redirect || fl_rem[k] > 0) begin
        e = 7'b1111111;
      end else if (lu) begin
        e = 7'b0001111;
      end else begin
        e = 7'b1101011;
      end
      act = {pc_en[k], if_id_en[k], if_id_flush[k], id_ex_en[k], id_ex_flush[k],
             ex_mem_en[k], mem_wb_en[k]};
      asc = (k == 0) ? longint'(sc0)  : longint'(sc1);
      afc = (k == 0) ? longint'(fcc0) : longint'(fcc1);
      chk($sformatf("ctl%0d", k), act, e);
      chk($sformatf("stall_count%0d", k), asc, sat(k, scm[k]));
      chk($sformatf("flush_count%0d", k), afc, sat(k, fcm[k]));
      if (rst_n) begin
        if (frz) scm[k]++;
        else if (ex_redirect) begin fcm[k]++; fl_rem[k] = fcyc[k] - 1; end
        else if (fl_rem[k] > 0) fl_rem[k]--;
        else if (lu) scm[k]++;
      end
    end
  endtask

  task automatic step(input stim_t s);
    @(posedge clk);
    #1;
    rst_n               = s.rst;
    id_ex_mem_rd_en     = s.mrd;
    id_ex_reg_a_wr_en   = s.wren;
    id_ex_reg_a_wr_addr = s.waddr;
    id_rd_addr1         = s.a1;
    id_rd_addr2         = s.a2;
    id_rd_use1          = s.u1;
    id_rd_use2          = s.u2;
    ex_redirect         = s.redir;
    mem_req             = s.req;
    mem_ack             = s.ack;
    @(negedge clk);
    model_cycle();
  endtask

  initial begin
    stim_t s;

    s = idle(); s.rst = 1'b0;
    step(s);
    chk("lit_reset_pc_en", pc_en[0], 0);
    chk("lit_reset_mem_wb_en", mem_wb_en[0], 0);

    step(idle());
    chk("lit_idle_pc_en", pc_en[0], 1);
    chk("lit_idle_if_id_flush", if_id_flush[0], 0);
    chk("lit_idle_stall", sc0, 0);

    // Load r3, decode reads r3 on source 2.
    s = idle(); s.mrd = 1; s.wren = 1; s.waddr = 3; s.a2 = 3; s.u2 = 1;
    step(s);
    chk("lit_lu_pc_en", pc_en[0], 0);
    chk("lit_lu_if_id_en", if_id_en[0], 0);
    chk("lit_lu_id_ex_flush", id_ex_flush[0], 1);
    step(idle());
    chk("lit_lu_release_pc_en", pc_en[0], 1);
    chk("lit_lu_stall", sc0, 1);

    s.waddr = 0; s.a2 = 0;
    step(s);
    chk("lit_lu_r0_pc_en", pc_en[0], 1);
    s.waddr = 3; s.a2 = 3; s.u2 = 0;
    step(s);
    chk("lit_lu_nouse_pc_en", pc_en[0], 1);

    s = idle(); s.redir = 1;
    step(s);
    chk("lit_redir_if_id_flush", if_id_flush[0], 1);
    chk("lit_redir_pc_en", pc_en[0], 1);
    step(idle());
    chk("lit_flush2_if_id_flush", if_id_flush[0], 1);
    chk("lit_fc1_flush_done", if_id_flush[1], 0);
    chk("lit_flush_count", fcc0, 1);
    step(idle());
    chk("lit_flush3_id_ex_flush", id_ex_flush[0], 1);
    step(idle());
    chk("lit_flush_end", if_id_flush[0], 0);

    // Four wait cycles; redirect raised during the last one.
    for (int i = 0; i < 4; i++) begin
      s = idle(); s.req = 1; s.redir = (i == 3);
      step(s);
      chk("lit_wait_pc_en", pc_en[0], 0);
      chk("lit_wait_ex_mem_en", ex_mem_en[0], 0);
    end
    s = idle(); s.req = 1; s.ack = 1; s.redir = 1;
    step(s);
    chk("lit_ack_pc_en", pc_en[0], 1);
    chk("lit_ack_if_id_flush", if_id_flush[0], 1);
    chk("lit_ack_stall", sc0, 5);
    step(idle());
    step(idle());
    step(idle());
    chk("lit_after_ack_flush_count", fcc0, 2);

    // Redirect and load-use together: flush wins.
    s = idle(); s.redir = 1; s.mrd = 1; s.wren = 1; s.waddr = 7; s.a1 = 7; s.u1 = 1;
    step(s);
    chk("lit_both_pc_en", pc_en[0], 1);
    chk("lit_both_if_id_flush", if_id_flush[0], 1);
    step(idle());
    chk("lit_both_stall", sc0, 5);
    s = idle(); s.redir = 1;
    step(s);
    step(idle());
    step(idle());
    chk("lit_extend_if_id_flush", if_id_flush[0], 1);
    step(idle());
    chk("lit_extend_end", if_id_flush[0], 0);
    chk("lit_extend_count", fcc0, 4);

    // Reset while flushing.
    s = idle(); s.redir = 1;
    step(s);
    s = idle(); s.rst = 0;
    step(s);
    chk("lit_rst_flush_pc_en", pc_en[0], 0);
    chk("lit_rst_flush_if_id_flush", if_id_flush[0], 0);
    chk("lit_rst_flush_count", fcc0, 0);
    step(idle());
    chk("lit_post_rst_if_id_flush", if_id_flush[0], 0);
    chk("lit_post_rst_pc_en", pc_en[0], 1);

    for (int i = 0; i < 20; i++) begin
      s = idle(); s.req = 1;
      step(s);
    end
    step(idle());
    chk("lit_sat_stall4", sc1, 15);
    chk("lit_nosat_stall32", sc0, 20);

    for (int i = 0; i < 4000; i++) begin
      s.rst   = ($urandom_range(0, 299) != 0);
      s.mrd   = $urandom_range(0, 1) == 1;
      s.wren  = $urandom_range(0, 3) != 0;
      s.waddr = AW'($urandom_range(0, 3));
      s.a1    = AW'($urandom_range(0, 3));
      s.a2    = AW'($urandom_range(0, 3));
      s.u1    = $urandom_range(0, 1) == 1;
      s.u2    = $urandom_range(0, 1) == 1;
      s.redir = $urandom_range(0, 7) == 0;
      s.req   = $urandom_range(0, 3) == 0;
      s.ack   = $urandom_range(0, 1) == 1;
      step(s);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipeline_hazard_ctrl
